mmio_timer: RTL and testbench

//  Data-bus responder for the single-cycle riscv core; sits beside data_mem on the data bus.

---
 rtl/mmio_timer.sv | 112 +++++++++++
 tb/tb_mmio_timer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with prescaler, compare match and irq, plus the sticky
// VERIFY/DONE registers used to end a program run. Combinational reads, edge writes.
module mmio_timer #(
  parameter logic [31:0] BASE  = 32'h0000_1000,
  parameter int          PRE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq,
  output logic [31:0] verify,
  output logic        done
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_COUNT  = 3'd1;
  localparam logic [2:0] OFF_CMP    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_VERIFY = 3'd4;
  localparam logic [2:0] OFF_DONE   = 3'd5;

  logic             en, auto_reload, irq_en;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [31:0]      count, cmp;
  logic             match, ovf;

  logic       sel, wr;
  logic [2:0] off;
  logic       tick, cnt_wr, hit, reload, wrap;
  logic       unused_ok;

  assign sel       = ce && (addr[31:5] == BASE[31:5]);
  assign off       = addr[4:2];
  assign wr        = sel && we;
  assign unused_ok = ^addr[1:0];

  // A CPU write to COUNT overrides the tick entirely: no match, no overflow that edge.
  assign tick   = en && (pre_cnt == prescale);
  assign cnt_wr = wr && (off == OFF_COUNT);
  assign hit    = tick && !cnt_wr && (count == cmp);
  assign reload = hit && auto_reload;
  assign wrap   = tick && !cnt_wr && !reload && (count == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      pre_cnt     <= '0;
      count       <= '0;
      cmp         <= '0;
      match       <= 1'b0;
      ovf         <= 1'b0;
      verify      <= '0;
      done        <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL) begin
        en          <= data_i[0];
        auto_reload <= data_i[1];
        irq_en      <= data_i[2];
        prescale    <= data_i[8 +: PRE_W];
        pre_cnt     <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      if (cnt_wr)    count <= data_i;
      else if (tick) count <= reload ? 32'h0 : count + 32'd1;

      if (wr && off == OFF_CMP) cmp <= data_i;

      // Hardware set wins over a same-edge write-1-to-clear.
      if (hit)                                       match <= 1'b1;
      else if (wr && off == OFF_STATUS && data_i[0]) match <= 1'b0;
      if (wrap)                                      ovf   <= 1'b1;
      else if (wr && off == OFF_STATUS && data_i[1]) ovf   <= 1'b0;

      if (wr && off == OFF_VERIFY) verify <= data_i;
      if (wr && off == OFF_DONE)   done   <= 1'b1;
    end
  end

  logic [31:0] rd;
  always_comb begin
    rd = '0;
    case (off)
      OFF_CTRL: begin
        rd[0]           = en;
        rd[1]           = auto_reload;
        rd[2]           = irq_en;
        rd[8 +: PRE_W]  = prescale;
      end
      OFF_COUNT:  rd = count;
      OFF_CMP:    rd = cmp;
      OFF_STATUS: rd = {30'b0, ovf, match};
      OFF_VERIFY: rd = verify;
      OFF_DONE:   rd = {31'b0, done};
      default:    rd = '0;
    endcase
  end

  assign data_o = (rst && sel && !we) ? rd : 32'h0;
  assign irq    = match && irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: vector table, directed multi-cycle sequences and a random
// phase checked against a cycle-level reference model of the register map.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'd0,  A_COUNT = BASE + 32'd4,
                          A_CMP  = BASE + 32'd8,  A_STAT  = BASE + 32'd12,
                          A_VER  = BASE + 32'd16, A_DONE  = BASE + 32'd20;

  logic        clk, rst, ce, we, irq, done;
  logic [31:0] addr, data_i, data_o, verify;

  mmio_timer #(.BASE(BASE), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .irq(irq), .verify(verify), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus write: occupies exactly one rising edge, returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  // Combinational read; consumes no edge.
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, data_o, exp);
    ce = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        ce, we;
    logic [31:0] addr, data, exp;
  } vec_t;

  // Reference model state
  int unsigned m_cnt, m_cmp, m_ver, m_pc, m_pre;
  bit          m_en, m_ar, m_ie, m_match, m_ovf, m_done;

  function automatic void model_reset();
    m_cnt = 0; m_cmp = 0; m_ver = 0; m_pc = 0; m_pre = 0;
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_ovf = 0; m_done = 0;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return (m_pre << 8) | (32'(m_ie) << 2) | (32'(m_ar) << 1) | 32'(m_en);
      1: return m_cnt;
      2: return m_cmp;
      3: return (32'(m_ovf) << 1) | 32'(m_match);
      4: return m_ver;
      5: return 32'(m_done);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_edge(input bit w, input int off, input logic [31:0] d);
    bit tick, cw, hit, rl, ov;
    tick = m_en && (m_pc == m_pre);
    cw   = w && off == 1;
    hit  = tick && !cw && (m_cnt == m_cmp);
    rl   = hit && m_ar;
    ov   = tick && !cw && !rl && (m_cnt == 32'hFFFF_FFFF);
    if (w && off == 0) m_pc = 0;
    else if (tick)     m_pc = 0;
    else if (m_en)     m_pc = m_pc + 1;
    if (cw)        m_cnt = d;
    else if (tick) m_cnt = rl ? 0 : m_cnt + 1;
    if (hit) m_match = 1; else if (w && off == 3 && d[0]) m_match = 0;
    if (ov)  m_ovf = 1;   else if (w && off == 3 && d[1]) m_ovf = 0;
    if (w && off == 0) begin
      m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_pre = 32'(d[15:8]);
    end
    if (w && off == 2) m_cmp = d;
    if (w && off == 4) m_ver = d;
    if (w && off == 5) m_done = 1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;

    // Reset state
    #3;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_verify", verify, 32'h0);
    rd("rst_read_ctrl", A_CTRL, 32'h0);
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset mid-run
    wr(A_DONE, 32'h1);
    wr(A_VER, 32'h1234);
    wr(A_CMP, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);
    step(); step();
    rd("run_count5", A_COUNT, 32'd5);
    chk("run_irq", {31'b0, irq}, 32'h1);
    chk("run_done", {31'b0, done}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    chk("arst_verify", verify, 32'h0);
    rd("arst_data", A_COUNT, 32'h0);
    @(negedge clk); rst = 1'b1;
    rd("post_rst_count", A_COUNT, 32'h0);
    rd("post_rst_stat", A_STAT, 32'h0);
    step();
    rd("post_rst_hold", A_COUNT, 32'h0);

    // Decode, VERIFY/DONE and register map vectors
    tbl.push_back('{1, 1, A_VER, 32'd55, 32'h0});
    tbl.push_back('{1, 0, A_VER, 32'h0, 32'd55});
    tbl.push_back('{1, 0, A_VER + 32'd3, 32'h0, 32'd55});
    tbl.push_back('{1, 1, A_DONE, 32'h0, 32'h0});
    tbl.push_back('{1, 0, A_DONE, 32'h0, 32'h1});
    tbl.push_back('{1, 1, BASE + 32'd24, 32'hDEAD, 32'h0});
    tbl.push_back('{1, 0, BASE + 32'd24, 32'h0, 32'h0});
    tbl.push_back('{1, 0, BASE + 32'd28, 32'h0, 32'h0});
    tbl.push_back('{1, 1, A_VER + 32'd32, 32'd99, 32'h0});
    tbl.push_back('{1, 0, A_VER + 32'd32, 32'h0, 32'h0});
    tbl.push_back('{1, 0, A_VER, 32'h0, 32'd55});
    tbl.push_back('{0, 1, A_VER, 32'd77, 32'h0});
    tbl.push_back('{0, 0, A_VER, 32'h0, 32'h0});
    tbl.push_back('{1, 0, A_VER, 32'h0, 32'd55});
    tbl.push_back('{1, 1, A_CTRL, 32'hFFFF_FFFE, 32'h0});
    tbl.push_back('{1, 0, A_CTRL, 32'h0, 32'h0000_FF06});
    tbl.push_back('{1, 1, A_CTRL, 32'h0, 32'h0});
    tbl.push_back('{1, 0, A_CTRL, 32'h0, 32'h0});
    tbl.push_back('{1, 1, A_CMP, 32'd3, 32'h0});
    tbl.push_back('{1, 0, A_CMP, 32'h0, 32'd3});
    foreach (tbl[i]) begin
      ce = tbl[i].ce; we = tbl[i].we; addr = tbl[i].addr; data_i = tbl[i].data;
      #1;
      chk($sformatf("vec%0d", i), data_o, tbl[i].exp);
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
    end
    chk("verify_out", verify, 32'd55);
    chk("done_out", {31'b0, done}, 32'h1);

    // Free run, prescale 0
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h1);
    rd("free_c0", A_COUNT, 32'd0);
    step(); rd("free_c1", A_COUNT, 32'd1);
    step(); rd("free_c2", A_COUNT, 32'd2);
    step(); rd("free_c3", A_COUNT, 32'd3);
    rd("free_nomatch", A_STAT, 32'h0);
    step(); rd("free_c4", A_COUNT, 32'd4);
    rd("free_match", A_STAT, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h3);

    // Prescale 2 with auto-reload: one tick per 3 cycles, COUNT wraps at CMP
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h0000_0203);
    for (int k = 1; k <= 12; k++) begin
      step();
      rd($sformatf("pre_count_k%0d", k), A_COUNT, 32'((k / 3) % 3));
      rd($sformatf("pre_stat_k%0d", k), A_STAT, (k >= 9) ? 32'h1 : 32'h0);
    end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h3);

    // irq, W1C and same-edge priorities
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h5);
    step(); step();
    chk("irq_low", {31'b0, irq}, 32'h0);
    step();
    chk("irq_high", {31'b0, irq}, 32'h1);
    wr(A_STAT, 32'h1);
    chk("irq_w1c", {31'b0, irq}, 32'h0);
    wr(A_COUNT, 32'd7);
    rd("cnt_write_beats_tick", A_COUNT, 32'd7);
    wr(A_CMP, 32'd8);
    rd("stat_before_clr", A_STAT, 32'h0);
    wr(A_STAT, 32'h1);
    chk("set_beats_clr_irq", {31'b0, irq}, 32'h1);
    rd("set_beats_clr", A_STAT, 32'h1);
    wr(A_STAT, 32'h3);
    wr(A_CMP, 32'd10);
    rd("cmp_old_used", A_STAT, 32'h0);
    rd("cmp_new", A_CMP, 32'd10);

    // Overflow, and auto-reload at all-ones does not flag overflow
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h3);
    wr(A_CMP, 32'd0);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    rd("ovf_pre", A_COUNT, 32'hFFFF_FFFF);
    step();
    rd("ovf_count", A_COUNT, 32'h0);
    rd("ovf_stat", A_STAT, 32'h2);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h3);
    wr(A_CMP, 32'hFFFF_FFFF);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h3);
    step();
    rd("reload_count", A_COUNT, 32'h0);
    rd("reload_stat", A_STAT, 32'h1);
    chk("reload_noirq", {31'b0, irq}, 32'h0);

    // Random traffic against the reference model
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 500; n++) begin
      int          off;
      logic [31:0] d;
      bit          sel;
      ce  = ($urandom_range(0, 9) != 0);
      we  = ($urandom_range(0, 2) == 0);
      off = $urandom_range(0, 7);
      addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = addr + 32'd32;
      d = $urandom;
      case (off)
        0: begin d[15:8] = 8'($urandom_range(0, 3)); d[0] = ($urandom_range(0, 4) != 0); end
        1: case ($urandom_range(0, 2))
             0: d = m_cmp - 1;
             1: d = 32'hFFFF_FFFE;
             default: d = $urandom;
           endcase
        2: d = $urandom_range(0, 6);
        3: d = $urandom_range(0, 3);
        default: ;
      endcase
      data_i = d;
      sel = ce && ((addr >> 5) == (BASE >> 5));
      #1;
      chk($sformatf("rnd%0d_data", n), data_o, (sel && !we) ? model_read(off) : 32'h0);
      chk($sformatf("rnd%0d_irq", n), {31'b0, irq}, {31'b0, m_match & m_ie});
      chk($sformatf("rnd%0d_verify", n), verify, m_ver);
      chk($sformatf("rnd%0d_done", n), {31'b0, done}, {31'b0, m_done});
      @(posedge clk);
      model_edge(sel && we, off, d);
      @(negedge clk);
    end
    ce = 1'b0; we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
